// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI retirement trace buffer: record layout, FSM states and
// the address-window filter.
package rvfi_trace_pkg;

    // Record ts field is fixed-width; narrower timestamp counters are zero-extended.
    localparam int unsigned TsMaxW = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [4:0]        rd_addr;
        logic [31:0]       rd_wdata;
        logic [31:0]       mem_addr;
        logic [3:0]        mem_rmask;
        logic [3:0]        mem_wmask;
        logic [TsMaxW-1:0] ts;
    } trace_rec_t;

    function automatic logic filter_hit(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (pc >= lo) && (pc <= hi);
    endfunction

endpackage

// File: rtl/rvfi_trace_ring.sv
// Circular record store. rptr is kept equal to (wptr - count) at all times, so the oldest
// valid entry is always at rptr and a write into a full ring drops it.
module rvfi_trace_ring
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   wr_en_i,
    input  trace_rec_t             wr_data_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   overwrite_o,
    output trace_rec_t             rd_data_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    trace_rec_t mem_q [DEPTH];

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    assign full_o      = (count_q == CntW'(DEPTH));
    assign overwrite_o = wr_en_i && !clr_i && full_o;
    assign count_o     = count_q;
    assign rd_data_o   = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else if (wr_en_i) begin
            wptr_d = wptr_q + PtrW'(1);
            if (full_o) begin
                rptr_d = rptr_q + PtrW'(1);
            end else begin
                count_d = count_q + CntW'(1);
            end
        end else if (pop_i && (count_q != '0)) begin
            rptr_d  = rptr_q + PtrW'(1);
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; contents are only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en_i && !clr_i) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer: filtered capture into a ring around a trigger, then an
// oldest-first drain over a valid/ready port.
module rvfi_trace_buffer
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned POST_TRIGGER = 4,
    parameter int unsigned TS_W         = 16,
    parameter bit          FILTER_EN    = 1'b1,
    parameter int unsigned NMEM         = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm_i,
    input  logic               clear_i,
    input  logic               trig_i,
    input  logic               trig_pc_en_i,
    input  logic [31:0]        trig_pc_i,
    input  logic [31:0]        filt_lo_i,
    input  logic [31:0]        filt_hi_i,
    input  logic               rvfi_valid,
    input  logic [31:0]        rvfi_pc_rdata,
    input  logic [4:0]         rvfi_rd_addr,
    input  logic [31:0]        rvfi_rd_wdata,
    input  logic [32*NMEM-1:0] rvfi_mem_addr,
    input  logic [4*NMEM-1:0]  rvfi_mem_rmask,
    input  logic [4*NMEM-1:0]  rvfi_mem_wmask,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output trace_rec_t         rd_rec_o,
    output logic [1:0]         state_o,
    output logic [15:0]        lost_o,
    output logic               done_o
);

    localparam int unsigned CntW  = $clog2(DEPTH) + 1;
    localparam int unsigned PcntW = (POST_TRIGGER > 0) ? $clog2(POST_TRIGGER + 1) : 1;

    trace_state_e     state_q, state_d;
    logic [PcntW-1:0] post_cnt_q, post_cnt_d;
    logic [15:0]      lost_q, lost_d;
    logic [TS_W-1:0]  ts_q;

    logic            accepted;
    logic            trigger;
    logic            wr_en;
    logic            ring_clr;
    logic            lost_clr;
    logic            pop;
    logic            full;
    logic            overwrite;
    logic [CntW-1:0] count;
    trace_rec_t      wr_rec;

    assign accepted = rvfi_valid &&
                      (!FILTER_EN || filter_hit(rvfi_pc_rdata, filt_lo_i, filt_hi_i));
    assign trigger  = trig_i || (trig_pc_en_i && accepted && (rvfi_pc_rdata == trig_pc_i));

    always_comb begin
        wr_rec           = '0;
        wr_rec.pc        = rvfi_pc_rdata;
        wr_rec.rd_addr   = rvfi_rd_addr;
        wr_rec.rd_wdata  = rvfi_rd_wdata;
        wr_rec.mem_addr  = rvfi_mem_addr[31:0];
        wr_rec.mem_rmask = rvfi_mem_rmask[3:0];
        wr_rec.mem_wmask = rvfi_mem_wmask[3:0];
        wr_rec.ts        = TsMaxW'(ts_q);
    end

    rvfi_trace_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (ring_clr),
        .wr_en_i     (wr_en),
        .wr_data_i   (wr_rec),
        .pop_i       (pop),
        .count_o     (count),
        .full_o      (full),
        .overwrite_o (overwrite),
        .rd_data_o   (rd_rec_o)
    );

    always_comb begin
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        wr_en      = 1'b0;
        ring_clr   = 1'b0;
        lost_clr   = 1'b0;
        pop        = 1'b0;
        done_o     = 1'b0;
        if (clear_i) begin
            state_d  = StIdle;
            ring_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm_i) begin
                        state_d  = StArmed;
                        ring_clr = 1'b1;
                        lost_clr = 1'b1;
                    end
                end
                StArmed: begin
                    wr_en = accepted;
                    if (trigger) begin
                        if (POST_TRIGGER == 0) begin
                            state_d = StDone;
                        end else begin
                            state_d    = StPost;
                            post_cnt_d = PcntW'(POST_TRIGGER);
                        end
                    end
                end
                StPost: begin
                    wr_en = accepted;
                    if (accepted) begin
                        post_cnt_d = post_cnt_q - PcntW'(1);
                        if (post_cnt_q == PcntW'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    pop = rd_ready_i && (count != '0);
                    // An empty capture still signals completion so the consumer is released.
                    if ((count == '0) || (pop && (count == CntW'(1)))) begin
                        done_o  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        lost_d = lost_q;
        if (lost_clr) begin
            lost_d = '0;
        end else if (overwrite && (lost_q != 16'hFFFF)) begin
            lost_d = lost_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            post_cnt_q <= '0;
            lost_q     <= '0;
            ts_q       <= '0;
        end else begin
            state_q    <= state_d;
            post_cnt_q <= post_cnt_d;
            lost_q     <= lost_d;
            ts_q       <= ts_q + TS_W'(1);
        end
    end

    assign rd_valid_o = (state_q == StDone) && (count != '0);
    assign state_o    = state_q;
    assign lost_o     = lost_q;

    // full is consumed through overwrite; keep the port for observability.
    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed bench: instance A (POST_TRIGGER=4) and instance B (POST_TRIGGER=0) share stimulus.
module tb_rvfi_trace_buffer;
    import rvfi_trace_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        arm_i, clear_i, trig_i, trig_pc_en_i;
    logic [31:0] trig_pc_i, filt_lo_i, filt_hi_i;
    logic        rvfi_valid;
    logic [31:0] rvfi_pc_rdata, rvfi_rd_wdata, rvfi_mem_addr;
    logic [4:0]  rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        rd_ready_a, rd_ready_b;

    logic        a_valid, b_valid, a_done, b_done;
    trace_rec_t  a_rec, b_rec;
    logic [1:0]  a_state, b_state;
    logic [15:0] a_lost, b_lost;

    int n_cmp  = 0;
    int n_fail = 0;

    trace_rec_t got[$];
    int         done_seen;
    int         stall_changes;
    bit         drain_timeout;

    rvfi_trace_buffer #(
        .DEPTH(16), .POST_TRIGGER(4), .TS_W(16), .FILTER_EN(1'b1), .NMEM(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .clear_i(clear_i), .trig_i(trig_i),
        .trig_pc_en_i(trig_pc_en_i), .trig_pc_i(trig_pc_i), .filt_lo_i(filt_lo_i),
        .filt_hi_i(filt_hi_i), .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rd_valid_o(a_valid), .rd_ready_i(rd_ready_a),
        .rd_rec_o(a_rec), .state_o(a_state), .lost_o(a_lost), .done_o(a_done)
    );

    rvfi_trace_buffer #(
        .DEPTH(16), .POST_TRIGGER(0), .TS_W(16), .FILTER_EN(1'b1), .NMEM(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .clear_i(clear_i), .trig_i(trig_i),
        .trig_pc_en_i(trig_pc_en_i), .trig_pc_i(trig_pc_i), .filt_lo_i(filt_lo_i),
        .filt_hi_i(filt_hi_i), .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rd_valid_o(b_valid), .rd_ready_i(rd_ready_b),
        .rd_rec_o(b_rec), .state_o(b_state), .lost_o(b_lost), .done_o(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic retire(input logic [31:0] pc, input logic trig);
        @(negedge clk);
        arm_i          = 1'b0;
        clear_i        = 1'b0;
        rvfi_valid     = 1'b1;
        rvfi_pc_rdata  = pc;
        rvfi_rd_addr   = pc[6:2];
        rvfi_rd_wdata  = ~pc;
        rvfi_mem_addr  = pc + 32'h1000;
        rvfi_mem_rmask = 4'hF;
        rvfi_mem_wmask = 4'h0;
        trig_i         = trig;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rvfi_valid = 1'b0;
        trig_i     = 1'b0;
        arm_i      = 1'b0;
        clear_i    = 1'b0;
    endtask

    task automatic trig_only();
        @(negedge clk);
        rvfi_valid = 1'b0;
        trig_i     = 1'b1;
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        rvfi_valid = 1'b0;
        trig_i     = 1'b0;
        arm_i      = 1'b1;
        @(negedge clk);
        arm_i = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        rvfi_valid = 1'b0;
        trig_i     = 1'b0;
        clear_i    = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    // Pops records from instance sel (0=A, 1=B) into got[]; ready held low for `stall`
    // cycles, then high or toggling.
    task automatic drain(input bit sel, input int stall, input bit toggle);
        trace_rec_t cur;
        trace_rec_t held;
        bit         was_stalled;
        bit         r;
        logic       v;
        int         after_done;
        got.delete();
        done_seen     = 0;
        stall_changes = 0;
        drain_timeout = 1'b1;
        was_stalled   = 1'b0;
        after_done    = 0;
        held          = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            rvfi_valid = 1'b0;
            trig_i     = 1'b0;
            if (cyc < stall) r = 1'b0;
            else if (toggle) r = (((cyc - stall) % 2) == 0);
            else r = 1'b1;
            rd_ready_a = !sel && r;
            rd_ready_b = sel && r;
            #1;
            v   = sel ? b_valid : a_valid;
            cur = sel ? b_rec : a_rec;
            if (v && r) got.push_back(cur);
            if (v && !r) begin
                if (was_stalled && (cur !== held)) stall_changes++;
                held        = cur;
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (sel ? b_done : a_done) done_seen++;
            if (done_seen > 0) begin
                after_done++;
                if (after_done > 3) begin
                    drain_timeout = 1'b0;
                    break;
                end
            end
        end
        rd_ready_a = 1'b0;
        rd_ready_b = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL reset_state_a: got %0d want 0", a_state); end
        n_cmp++; if (b_state !== 2'd0) begin n_fail++; $display("FAIL reset_state_b: got %0d want 0", b_state); end
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_lost !== 16'd0) begin n_fail++; $display("FAIL reset_lost: got %0d want 0", a_lost); end
        n_cmp++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", a_done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pc_trigger();
        logic [31:0] exp_pc;
        filt_lo_i    = 32'h0;
        filt_hi_i    = 32'hFFFF_FFFF;
        trig_pc_en_i = 1'b1;
        trig_pc_i    = 32'h150;
        pulse_arm();
        n_cmp++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL pct_armed: got %0d want 1", a_state); end
        for (int k = 0; k < 30; k++) retire(32'h100 + 32'(4 * k), 1'b0);
        idle_cycle();
        trig_pc_en_i = 1'b0;
        #1;
        n_cmp++; if (a_state !== 2'd3) begin n_fail++; $display("FAIL pct_done_state: got %0d want 3", a_state); end
        n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL pct_valid: got %b want 1", a_valid); end
        n_cmp++; if (a_lost !== 16'd9) begin n_fail++; $display("FAIL pct_lost: got %0d want 9", a_lost); end
        drain(1'b0, 0, 1'b0);
        n_cmp++; if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL pct_drain_timeout: got %b want 0", drain_timeout); end
        n_cmp++; if (got.size() != 16) begin n_fail++; $display("FAIL pct_count: got %0d want 16", got.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < got.size()) begin
                exp_pc = 32'h124 + 32'(4 * i);
                n_cmp++;
                if (got[i].pc !== exp_pc || got[i].rd_wdata !== ~exp_pc ||
                    got[i].mem_addr !== exp_pc + 32'h1000 || got[i].rd_addr !== exp_pc[6:2] ||
                    got[i].mem_rmask !== 4'hF || got[i].mem_wmask !== 4'h0 ||
                    got[i].ts[15:0] !== 16'(got[0].ts[15:0] + 16'(i))) begin
                    n_fail++;
                    $display("FAIL pct_rec%0d: got pc=%h wdata=%h maddr=%h ts=%h want pc=%h", i,
                             got[i].pc, got[i].rd_wdata, got[i].mem_addr, got[i].ts, exp_pc);
                end
            end
        end
        n_cmp++; if (done_seen != 1) begin n_fail++; $display("FAIL pct_done_pulses: got %0d want 1", done_seen); end
        n_cmp++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL pct_idle_after: got %0d want 0", a_state); end
        n_cmp++; if (a_lost !== 16'd9) begin n_fail++; $display("FAIL pct_lost_held: got %0d want 9", a_lost); end
    endtask

    task automatic test_filter();
        logic [31:0] exp_pc [5];
        exp_pc[0] = 32'h200; exp_pc[1] = 32'h204; exp_pc[2] = 32'h208;
        exp_pc[3] = 32'h20C; exp_pc[4] = 32'h2FF;
        pulse_clear();
        filt_lo_i = 32'h200;
        filt_hi_i = 32'h2FF;
        pulse_arm();
        n_cmp++; if (b_lost !== 16'd0) begin n_fail++; $display("FAIL filt_lost_armed: got %0d want 0", b_lost); end
        for (int k = 0; k < 8; k++) begin
            if ((k % 2) == 0) retire(32'h1F0, 1'b0);
            else retire(32'h200 + 32'(4 * (k / 2)), 1'b0);
        end
        retire(32'h2FF, 1'b0);
        retire(32'h300, 1'b0);
        trig_only();
        idle_cycle();
        #1;
        n_cmp++; if (b_state !== 2'd3) begin n_fail++; $display("FAIL filt_state: got %0d want 3", b_state); end
        n_cmp++; if (b_lost !== 16'd0) begin n_fail++; $display("FAIL filt_lost: got %0d want 0", b_lost); end
        drain(1'b1, 0, 1'b0);
        n_cmp++; if (got.size() != 5) begin n_fail++; $display("FAIL filt_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) begin
                n_cmp++;
                if (got[i].pc !== exp_pc[i]) begin
                    n_fail++; $display("FAIL filt_rec%0d: got %h want %h", i, got[i].pc, exp_pc[i]);
                end
            end
        end
        n_cmp++; if (done_seen != 1) begin n_fail++; $display("FAIL filt_done: got %0d want 1", done_seen); end
    endtask

    task automatic test_post0();
        pulse_clear();
        filt_lo_i = 32'h0;
        filt_hi_i = 32'hFFFF_FFFF;
        pulse_arm();
        retire(32'h400, 1'b0);
        retire(32'h404, 1'b0);
        retire(32'h408, 1'b0);
        retire(32'h40C, 1'b1);
        idle_cycle();
        #1;
        n_cmp++; if (b_state !== 2'd3) begin n_fail++; $display("FAIL p0_state: got %0d want 3", b_state); end
        drain(1'b1, 0, 1'b0);
        n_cmp++; if (got.size() != 4) begin n_fail++; $display("FAIL p0_count: got %0d want 4", got.size()); end
        if (got.size() == 4) begin
            n_cmp++; if (got[0].pc !== 32'h400) begin n_fail++; $display("FAIL p0_first: got %h want 400", got[0].pc); end
            n_cmp++; if (got[3].pc !== 32'h40C) begin n_fail++; $display("FAIL p0_last: got %h want 40c", got[3].pc); end
        end
        // Trigger into an empty buffer: completes without any record.
        pulse_clear();
        pulse_arm();
        trig_only();
        idle_cycle();
        #1;
        n_cmp++; if (b_done !== 1'b1) begin n_fail++; $display("FAIL p0_empty_done: got %b want 1", b_done); end
        n_cmp++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL p0_empty_valid: got %b want 0", b_valid); end
        idle_cycle();
        #1;
        n_cmp++; if (b_state !== 2'd0) begin n_fail++; $display("FAIL p0_empty_idle: got %0d want 0", b_state); end
    endtask

    task automatic test_backpressure();
        pulse_clear();
        pulse_arm();
        for (int k = 0; k < 10; k++) retire(32'h500 + 32'(4 * k), (k == 5));
        idle_cycle();
        #1;
        n_cmp++; if (a_state !== 2'd3) begin n_fail++; $display("FAIL bp_state: got %0d want 3", a_state); end
        drain(1'b0, 5, 1'b1);
        n_cmp++; if (stall_changes != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", stall_changes); end
        n_cmp++; if (got.size() != 10) begin n_fail++; $display("FAIL bp_count: got %0d want 10", got.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) begin
                n_cmp++;
                if (got[i].pc !== 32'h500 + 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL bp_rec%0d: got %h want %h", i, got[i].pc, 32'h500 + 32'(4 * i));
                end
            end
        end
        n_cmp++; if (done_seen != 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_seen); end
    endtask

    task automatic test_clear();
        pulse_clear();
        pulse_arm();
        for (int k = 0; k < 20; k++) retire(32'h500 + 32'(4 * k), (k == 15));
        idle_cycle();
        #1;
        n_cmp++; if (a_lost !== 16'd4) begin n_fail++; $display("FAIL clr_lost: got %0d want 4", a_lost); end
        @(negedge clk);
        rd_ready_a = 1'b1;
        #1;
        n_cmp++; if (a_rec.pc !== 32'h510) begin n_fail++; $display("FAIL clr_pop0: got %h want 510", a_rec.pc); end
        @(negedge clk);
        #1;
        n_cmp++; if (a_rec.pc !== 32'h514) begin n_fail++; $display("FAIL clr_pop1: got %h want 514", a_rec.pc); end
        @(negedge clk);
        rd_ready_a = 1'b0;
        clear_i    = 1'b1;
        #1;
        n_cmp++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL clr_no_done: got %b want 0", a_done); end
        @(negedge clk);
        clear_i = 1'b0;
        #1;
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL clr_state: got %0d want 0", a_state); end
        n_cmp++; if (a_lost !== 16'd4) begin n_fail++; $display("FAIL clr_lost_held: got %0d want 4", a_lost); end
        @(negedge clk);
        arm_i   = 1'b1;
        clear_i = 1'b1;
        @(negedge clk);
        arm_i   = 1'b0;
        clear_i = 1'b0;
        #1;
        n_cmp++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL clr_arm_and_clear: got %0d want 0", a_state); end
        pulse_arm();
        n_cmp++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL clr_rearm_state: got %0d want 1", a_state); end
        n_cmp++; if (a_lost !== 16'd0) begin n_fail++; $display("FAIL clr_rearm_lost: got %0d want 0", a_lost); end
        trig_only();
        for (int k = 0; k < 4; k++) retire(32'h600 + 32'(4 * k), 1'b0);
        idle_cycle();
        drain(1'b0, 0, 1'b0);
        n_cmp++; if (got.size() != 4) begin n_fail++; $display("FAIL clr_rearm_count: got %0d want 4", got.size()); end
        if (got.size() > 0) begin
            n_cmp++; if (got[0].pc !== 32'h600) begin n_fail++; $display("FAIL clr_rearm_first: got %h want 600", got[0].pc); end
        end
    endtask

    task automatic test_reset_in_post();
        pulse_clear();
        pulse_arm();
        for (int k = 0; k < 7; k++) retire(32'h700 + 32'(4 * k), (k == 4));
        @(negedge clk);
        rvfi_valid = 1'b0;
        trig_i     = 1'b0;
        #1;
        n_cmp++; if (a_state !== 2'd2) begin n_fail++; $display("FAIL rp_post: got %0d want 2", a_state); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL rp_state: got %0d want 0", a_state); end
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rp_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_lost !== 16'd0) begin n_fail++; $display("FAIL rp_lost: got %0d want 0", a_lost); end
        n_cmp++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rp_done: got %b want 0", a_done); end
        @(negedge clk);
        rst_n = 1'b1;
        arm_i = 1'b1;
        retire(32'h800, 1'b1);
        for (int k = 1; k < 5; k++) retire(32'h800 + 32'(4 * k), 1'b0);
        idle_cycle();
        drain(1'b0, 0, 1'b0);
        n_cmp++; if (got.size() != 5) begin n_fail++; $display("FAIL rp_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) begin
                n_cmp++;
                if (got[i].ts !== 32'(i + 1) || got[i].pc !== 32'h800 + 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL rp_rec%0d: got pc=%h ts=%0d want pc=%h ts=%0d", i, got[i].pc,
                             got[i].ts, 32'h800 + 32'(4 * i), i + 1);
                end
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        arm_i          = 1'b0;
        clear_i        = 1'b0;
        trig_i         = 1'b0;
        trig_pc_en_i   = 1'b0;
        trig_pc_i      = 32'h0;
        filt_lo_i      = 32'h0;
        filt_hi_i      = 32'hFFFF_FFFF;
        rvfi_valid     = 1'b0;
        rvfi_pc_rdata  = 32'h0;
        rvfi_rd_addr   = 5'h0;
        rvfi_rd_wdata  = 32'h0;
        rvfi_mem_addr  = 32'h0;
        rvfi_mem_rmask = 4'h0;
        rvfi_mem_wmask = 4'h0;
        rd_ready_a     = 1'b0;
        rd_ready_b     = 1'b0;
        test_reset();
        test_pc_trigger();
        test_filter();
        test_post0();
        test_backpressure();
        test_clear();
        test_reset_in_post();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
